// File: rtl/riscv_pc_pkg.sv
// Shared definitions for the PC fetch controller: fetch FSM states,
// default PC geometry, counter width and the control-bundle type.
package riscv_pc_pkg;

  localparam int unsigned XLEN_DEFAULT    = 64;
  localparam int unsigned PC_STEP_DEFAULT = 4;
  localparam int unsigned CNT_W           = 32;

  typedef enum logic [1:0] {
    ST_BOOT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_MEMWAIT    = 2'd2,
    ST_REDIR_PEND = 2'd3
  } fetch_state_e;

  // Load enables / bubble controls driven toward the PC and IF/ID, ID/EX.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } fetch_ctrl_t;

  // Control pattern shared by BOOT and every applied or pending redirect.
  function automatic fetch_ctrl_t ctrl_all_flush(input logic pc_write);
    fetch_ctrl_t c;
    c.pc_write    = pc_write;
    c.if_id_write = 1'b1;
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pc_fetch_controller_sat_counter.sv
// 32-bit event counter with synchronous clear that sticks at all-ones
// instead of wrapping.
module sat_counter
  import riscv_pc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full  = &r_count;
  assign o_count = r_count;

  // Clear wins over increment; increment is suppressed once saturated.
  always_ff @(posedge i_clk) begin
    if (i_clr)
      r_count <= '0;
    else if (i_inc && !w_full)
      r_count <= r_count + CNT_W'(1);
  end

endmodule

// File: rtl/pc_fetch_controller.sv
// Next-PC selection and fetch/decode hazard control. Outputs are Mealy:
// they depend on the registered fetch state plus the current-cycle inputs,
// so a redirect with imem_ready=1 lands in the PC on the same rising edge.
// A redirect that arrives while memory is busy is parked in pend_target
// and applied on the first cycle memory is ready again.
module pc_fetch_controller
  import riscv_pc_pkg::*;
#(
  parameter int unsigned      XLEN         = XLEN_DEFAULT,
  parameter int unsigned      PC_STEP      = PC_STEP_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_current,
  input  logic             imem_ready,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             load_use_hazard,
  output logic [XLEN-1:0]  pc_next,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] redirect_count
);

  fetch_state_e     r_state;
  logic [XLEN-1:0]  r_pend_target;

  fetch_state_e     w_state_nxt;
  logic [XLEN-1:0]  w_pend_nxt;
  logic [XLEN-1:0]  w_pc_seq;
  logic [XLEN-1:0]  w_pc_next;
  fetch_ctrl_t      w_ctrl;
  logic             w_redirect;
  logic             w_stall;

  // Sequential advance; overflow past the top of the address space wraps.
  assign w_pc_seq = pc_current + XLEN'(PC_STEP);

  // Output and next-state decode; reset forces the BOOT output pattern.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_target;
    w_pc_next   = pc_current;       // held PC whenever PCWrite is low
    w_ctrl      = '0;
    w_redirect  = 1'b0;

    if (reset) begin
      w_pc_next   = RESET_VECTOR;
      w_ctrl      = ctrl_all_flush(1'b1);
      w_state_nxt = ST_BOOT;
      w_pend_nxt  = RESET_VECTOR;
    end else begin
      unique case (r_state)
        ST_BOOT: begin
          w_pc_next   = RESET_VECTOR;
          w_ctrl      = ctrl_all_flush(1'b1);
          w_state_nxt = ST_RUN;
        end

        ST_RUN, ST_MEMWAIT: begin
          if (branch_taken) begin
            if (imem_ready) begin
              w_pc_next   = branch_target;
              w_ctrl      = ctrl_all_flush(1'b1);
              w_redirect  = 1'b1;
              w_state_nxt = ST_RUN;
            end else begin
              // Memory busy: squash the wrong path now, remember the target.
              w_ctrl      = ctrl_all_flush(1'b0);
              w_pend_nxt  = branch_target;
              w_state_nxt = ST_REDIR_PEND;
            end
          end else if (load_use_hazard) begin
            // Freeze PC and IF/ID, bubble into ID/EX; state kept as is.
            w_ctrl.id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            w_ctrl.if_id_write = 1'b1;
            w_ctrl.if_id_flush = 1'b1;
            w_state_nxt        = ST_MEMWAIT;
          end else begin
            w_pc_next          = w_pc_seq;
            w_ctrl.pc_write    = 1'b1;
            w_ctrl.if_id_write = 1'b1;
            w_state_nxt        = ST_RUN;
          end
        end

        ST_REDIR_PEND: begin
          if (imem_ready) begin
            // A younger taken branch this cycle supersedes the parked one.
            w_pc_next   = branch_taken ? branch_target : r_pend_target;
            w_ctrl      = ctrl_all_flush(1'b1);
            w_redirect  = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_ctrl = ctrl_all_flush(1'b0);
            if (branch_taken)
              w_pend_nxt = branch_target;
          end
        end

        default: begin
          w_pc_next   = RESET_VECTOR;
          w_ctrl      = ctrl_all_flush(1'b1);
          w_state_nxt = ST_BOOT;
        end
      endcase
    end
  end

  // BOOT never counts as a stall even though nothing is held there.
  assign w_stall = !w_ctrl.pc_write && (r_state != ST_BOOT) && !reset;

  assign pc_next     = w_pc_next;
  assign PCWrite     = w_ctrl.pc_write;
  assign IF_ID_Write = w_ctrl.if_id_write;
  assign IF_ID_Flush = w_ctrl.if_id_flush;
  assign ID_EX_Flush = w_ctrl.id_ex_flush;

  // FSM state and parked redirect target; reset drops any pending redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_pend_target <= RESET_VECTOR;
    end else begin
      r_state       <= w_state_nxt;
      r_pend_target <= w_pend_nxt;
    end
  end

  sat_counter u_stall_cnt (
    .i_clk   (clock),
    .i_clr   (reset),
    .i_inc   (w_stall),
    .o_count (stall_count)
  );

  sat_counter u_redir_cnt (
    .i_clk   (clock),
    .i_clr   (reset),
    .i_inc   (w_redirect),
    .o_count (redirect_count)
  );

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: a vector table walks every FSM path,
// followed by hand sequences for redirect latency, pending redirects,
// load-use holds, PC wrap and counter saturation.
module tb_pc_fetch_controller;

  localparam int XLEN = 64;
  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;
  localparam logic [63:0] Z = 64'h0;

  logic            clock = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pc_current, branch_target, pc_next;
  logic            imem_ready, branch_taken, load_use_hazard;
  logic            PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic [31:0]     stall_count, redirect_count;

  always #5 clock = ~clock;

  pc_fetch_controller #(
    .XLEN(64), .PC_STEP(4), .RESET_VECTOR(64'h0)
  ) dut (
    .clock(clock), .reset(reset), .pc_current(pc_current),
    .imem_ready(imem_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .load_use_hazard(load_use_hazard),
    .pc_next(pc_next), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .stall_count(stall_count), .redirect_count(redirect_count)
  );

  // inputs, then expected {PCWrite,IF_ID_Write,IF_ID_Flush,ID_EX_Flush}
  // and whether this cycle applies a redirect
  typedef struct {
    logic        rst;
    logic [63:0] pc;
    logic        rdy;
    logic        br;
    logic [63:0] tgt;
    logic        hz;
    logic [63:0] e_pc;
    logic [3:0]  e_ctl;
    logic        e_rd;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] pc;
    logic [3:0]  ctl;
    logic [31:0] st;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          vid   = 0;
  logic [31:0] m_st  = 32'h0;
  logic [31:0] m_rd  = 32'h0;
  vec_t        tbl[21];

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Drive one cycle's inputs, queue its expectation, compare at negedge.
  task automatic step(input vec_t v);
    exp_t e;
    exp_t g;
    @(posedge clock);
    #1;
    reset = v.rst; pc_current = v.pc; imem_ready = v.rdy;
    branch_taken = v.br; branch_target = v.tgt; load_use_hazard = v.hz;
    e.id = vid; e.pc = v.e_pc; e.ctl = v.e_ctl; e.st = m_st; e.rd = m_rd;
    sb.push_back(e);
    vid++;
    // counter model advances for the coming edge
    if (v.rst) begin
      m_st = 32'h0;
      m_rd = 32'h0;
    end else begin
      if (!v.e_ctl[3] && m_st != 32'hFFFF_FFFF) m_st = m_st + 32'd1;
      if (v.e_rd && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 32'd1;
    end
    @(negedge clock);
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard vec%0d: got empty queue expected entry", vid);
    end else begin
      g = sb.pop_front();
      chk("pc_next",        g.id, pc_next, g.pc);
      chk("PCWrite",        g.id, 64'(PCWrite),     64'(g.ctl[3]));
      chk("IF_ID_Write",    g.id, 64'(IF_ID_Write), 64'(g.ctl[2]));
      chk("IF_ID_Flush",    g.id, 64'(IF_ID_Flush), 64'(g.ctl[1]));
      chk("ID_EX_Flush",    g.id, 64'(ID_EX_Flush), 64'(g.ctl[0]));
      chk("stall_count",    g.id, 64'(stall_count),    64'(g.st));
      chk("redirect_count", g.id, 64'(redirect_count), 64'(g.rd));
    end
  endtask

  task automatic do_reset();
    step('{L1, Z, L0, L0, Z, L0, Z, 4'b1111, L0});
    step('{L0, Z, L1, L0, Z, L0, Z, 4'b1111, L0});   // BOOT
  endtask

  initial begin
    reset = 1'b1; pc_current = Z; imem_ready = 1'b0;
    branch_taken = 1'b0; branch_target = Z; load_use_hazard = 1'b0;

    tbl[0]  = '{L1, 64'hDEAD, L0, L1, 64'h55,  L1, Z,       4'b1111, L0}; // in reset
    tbl[1]  = '{L0, Z,        L1, L0, Z,       L0, Z,       4'b1111, L0}; // BOOT
    tbl[2]  = '{L0, Z,        L1, L0, Z,       L0, 64'h4,   4'b1100, L0};
    tbl[3]  = '{L0, 64'h4,    L1, L0, Z,       L0, 64'h8,   4'b1100, L0};
    tbl[4]  = '{L0, 64'h8,    L0, L0, Z,       L0, 64'h8,   4'b0110, L0}; // -> MEMWAIT
    tbl[5]  = '{L0, 64'h8,    L1, L0, Z,       L0, 64'hC,   4'b1100, L0};
    tbl[6]  = '{L0, 64'hC,    L1, L0, Z,       L1, 64'hC,   4'b0001, L0}; // load-use
    tbl[7]  = '{L0, 64'hC,    L0, L1, 64'h200, L1, 64'hC,   4'b0111, L0}; // -> REDIR_PEND
    tbl[8]  = '{L0, 64'hC,    L0, L0, Z,       L1, 64'hC,   4'b0111, L0};
    tbl[9]  = '{L0, 64'hC,    L0, L1, 64'h240, L0, 64'hC,   4'b0111, L0}; // overwrite pend
    tbl[10] = '{L0, 64'hC,    L1, L0, Z,       L1, 64'h240, 4'b1111, L1}; // apply pend
    tbl[11] = '{L0, 64'h240,  L1, L1, 64'h400, L1, 64'h400, 4'b1111, L1}; // branch beats hazard
    tbl[12] = '{L0, 64'h400,  L0, L1, 64'h500, L0, 64'h400, 4'b0111, L0};
    tbl[13] = '{L0, 64'h400,  L1, L1, 64'h600, L0, 64'h600, 4'b1111, L1}; // new branch wins
    tbl[14] = '{L0, 64'h600,  L0, L0, Z,       L0, 64'h600, 4'b0110, L0};
    tbl[15] = '{L0, 64'h600,  L1, L0, Z,       L1, 64'h600, 4'b0001, L0}; // hazard in MEMWAIT
    tbl[16] = '{L0, 64'h600,  L1, L1, 64'h800, L0, 64'h800, 4'b1111, L1};
    tbl[17] = '{L0, 64'h800,  L0, L1, 64'h900, L0, 64'h800, 4'b0111, L0};
    tbl[18] = '{L1, 64'h800,  L1, L1, 64'hA00, L1, Z,       4'b1111, L0}; // reset in REDIR_PEND
    tbl[19] = '{L0, Z,        L1, L0, Z,       L0, Z,       4'b1111, L0};
    tbl[20] = '{L0, Z,        L1, L0, Z,       L0, 64'h4,   4'b1100, L0}; // 0x900 discarded

    for (int i = 0; i < 21; i++) step(tbl[i]);

    // zero-latency redirect from RUN
    do_reset();
    step('{L0, 64'h100, L1, L1, 64'h200, L0, 64'h200, 4'b1111, L1});
    step('{L0, 64'h200, L1, L0, Z,       L0, 64'h204, 4'b1100, L0});

    // redirect held off by 3 busy memory cycles
    do_reset();
    step('{L0, 64'h100, L0, L1, 64'h300, L0, 64'h100, 4'b0111, L0});
    step('{L0, 64'h100, L0, L1, 64'h300, L0, 64'h100, 4'b0111, L0});
    step('{L0, 64'h100, L0, L1, 64'h300, L0, 64'h100, 4'b0111, L0});
    step('{L0, 64'h100, L1, L0, Z,       L0, 64'h300, 4'b1111, L1});
    step('{L0, 64'h300, L1, L0, Z,       L0, 64'h304, 4'b1100, L0}); // stall=3, redir=1

    // single-cycle load-use hold
    step('{L0, 64'h40, L1, L0, Z, L1, 64'h40, 4'b0001, L0});
    step('{L0, 64'h40, L1, L0, Z, L0, 64'h44, 4'b1100, L0});

    // PC wraps past the top of the address space
    step('{L0, 64'hFFFF_FFFF_FFFF_FFFC, L1, L0, Z, L0, Z, 4'b1100, L0});

    // stall counter sticks at all-ones
    force dut.u_stall_cnt.r_count = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.r_count;
    m_st = 32'hFFFF_FFFF;
    step('{L0, Z, L0, L0, Z, L0, Z,     4'b0110, L0});
    step('{L0, Z, L0, L0, Z, L0, Z,     4'b0110, L0});
    step('{L0, Z, L1, L0, Z, L0, 64'h4, 4'b1100, L0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_controller.md
PC_FETCH_CONTROLLER -- requirements
Module: pc_fetch_controller

Interface
REQ-001 SHALL have parameter XLEN, default 64: PC width in bits.
REQ-002 SHALL have parameter PC_STEP, default 4: sequential increment in bytes.
REQ-003 SHALL have parameter RESET_VECTOR, default 0: first fetch address.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pc_current  input  XLEN  current value of the program counter register.
REQ-007 imem_ready  input  1  instruction memory returns a valid instruction for pc_current this cycle.
REQ-008 branch_taken  input  1  EX stage resolved a taken branch or jump.
REQ-009 branch_target  input  XLEN  redirect address, valid when branch_taken=1.
REQ-010 load_use_hazard  input  1  hazard unit requests a one-cycle fetch/decode hold (level).
REQ-011 pc_next  output  XLEN  value for the PC input port.
REQ-012 PCWrite  output  1  PC register load enable.
REQ-013 IF_ID_Write  output  1  IF/ID pipeline register load enable.
REQ-014 IF_ID_Flush  output  1  load bubble into IF/ID.
REQ-015 ID_EX_Flush  output  1  load bubble into ID/EX.
REQ-016 stall_count  output  32  saturating count of cycles with PCWrite=0 outside BOOT.
REQ-017 redirect_count  output  32  saturating count of applied redirects.

Function
REQ-018 SHALL implement states BOOT, RUN, MEMWAIT, REDIR_PEND; outputs are combinational from state and inputs (Mealy); state, pend_target and counters are registered.
REQ-019 BOOT: pc_next=RESET_VECTOR, PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1; next state RUN unconditionally; all other inputs ignored.
REQ-020 RUN/MEMWAIT, branch_taken=1 and imem_ready=1: pc_next=branch_target, PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1; redirect_count increments; next RUN.
REQ-021 RUN/MEMWAIT, branch_taken=1 and imem_ready=0: pend_target<=branch_target, PCWrite=0, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1; next REDIR_PEND.
REQ-022 RUN/MEMWAIT, branch_taken=0, load_use_hazard=1: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Flush=1; state unchanged; branch_taken has priority over load_use_hazard.
REQ-023 RUN/MEMWAIT, branch_taken=0, load_use_hazard=0, imem_ready=0: PCWrite=0, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=0; next MEMWAIT.
REQ-024 RUN/MEMWAIT, no branch, no hazard, imem_ready=1: pc_next=pc_current+PC_STEP (modulo 2^XLEN, wraps silently), PCWrite=1, IF_ID_Write=1, flushes 0; next RUN.
REQ-025 REDIR_PEND, imem_ready=0: PCWrite=0, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1; a new branch_taken=1 overwrites pend_target with branch_target.
REQ-026 REDIR_PEND, imem_ready=1: pc_next=(branch_taken ? branch_target : pend_target), PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1; redirect_count increments; next RUN; load_use_hazard ignored.
REQ-027 When PCWrite=0, pc_next SHALL equal pc_current.
REQ-028 Redirect latency SHALL be zero cycles with imem_ready=1 (PC holds target after the same rising edge).
REQ-029 Counters SHALL saturate at 32'hFFFF_FFFF and never wrap.

Reset
REQ-030 reset=1 at a rising edge SHALL force state BOOT, pend_target=RESET_VECTOR, stall_count=0, redirect_count=0, from any state including REDIR_PEND (pending redirect discarded).
REQ-031 While reset=1, outputs SHALL be the BOOT values of REQ-019.

Structure
REQ-032 Shared package riscv_pc_pkg SHALL hold the state enumeration, XLEN default and PC_STEP default.
REQ-033 Counters SHALL use one sub-module sat_counter (32-bit, synchronous clear, increment enable, saturating), instantiated twice.

Verification
REQ-034 Reset then 3 cycles imem_ready=1, pc_current follows pc_next -> pc_next sequence 0x0, 0x4, 0x8; flushes only in BOOT.
REQ-035 RUN, pc_current=0x100, branch_taken=1, target=0x200, imem_ready=1 -> pc_next=0x200, PCWrite=1, both flushes=1, redirect_count=1.
REQ-036 RUN, branch_taken=1, target=0x300, imem_ready=0 for 3 cycles then 1 -> PCWrite=0 for 3 cycles, pc_next=0x300 on cycle 4, stall_count=3.
REQ-037 RUN, load_use_hazard=1 for 1 cycle at pc_current=0x40 -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, pc_next=0x40; following cycle pc_next=0x44.
REQ-038 Simultaneous branch_taken=1 and load_use_hazard=1 -> redirect wins (REQ-020); then reset during REDIR_PEND -> BOOT, pc_next=RESET_VECTOR, counters 0.
REQ-039 pc_current=0xFFFF_FFFF_FFFF_FFFC, normal advance -> pc_next=0x0; forced stall_count=0xFFFF_FFFF plus stall -> remains 0xFFFF_FFFF.
